// File: rtl/usb_serial_wb_master_pkg.sv
// Shared register map, status bit positions and FSM encoding for the USB-serial
// Wishbone master (the slave side uses the same offsets and bit positions).
package usb_serial_wb_master_pkg;

   localparam logic [7:0] REG_DATA   = 8'h00;
   localparam logic [7:0] REG_STATUS = 8'h01;

   localparam int ST_RXV = 0;
   localparam int ST_TXR = 1;
   localparam int ST_CFG = 7;

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_POLL    = 2'd1,
      S_RD_DATA = 2'd2,
      S_WR_DATA = 2'd3
   } wbm_state_e;

endpackage

// File: rtl/usb_wbm_rx_fifo.sv
// Small synchronous FIFO for bytes received from the host; the head entry is
// read combinationally so the consumer sees it in the same cycle as empty drops.
module usb_wbm_rx_fifo #(
   parameter int AW = 2,
   parameter int DW = 8
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          push,
   input  logic [DW-1:0] push_data,
   input  logic          pop,
   output logic          full,
   output logic          empty,
   output logic [DW-1:0] head
);

   localparam int DEPTH = 2 ** AW;

   logic [DW-1:0] mem_q [DEPTH];
   logic [AW:0]   wr_ptr_q, wr_ptr_d;
   logic [AW:0]   rd_ptr_q, rd_ptr_d;
   logic          do_push, do_pop;

   // Extra pointer bit distinguishes full from empty when the low bits match.
   assign empty   = (wr_ptr_q == rd_ptr_q);
   assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                    (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign head    = mem_q[rd_ptr_q[AW-1:0]];

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (do_push) wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, 1'b1};
      if (do_pop)  rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, 1'b1};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= push_data;
   end

endmodule

// File: rtl/usb_serial_wb_master.sv
// Wishbone master that polls the USB-serial slave status, drains received bytes into
// an RX FIFO and forwards a TX stream. Optional ack timeout: define USB_WBM_TIMEOUT_EN.
module usb_serial_wb_master
   import usb_serial_wb_master_pkg::*;
#(
   parameter logic [7:0] BASE_ADDR   = 8'h20,
   parameter int         POLL_DIV    = 48,
   parameter int         RX_FIFO_AW  = 2,
   parameter int         ACK_TIMEOUT = 15
) (
   input  logic       clk,
   input  logic       rst_n,
   output logic [7:0] wb_adr_o,
   output logic [7:0] wb_dat_o,
   input  logic [7:0] wb_dat_i,
   output logic       wb_cyc_o,
   output logic       wb_stb_o,
   output logic       wb_we_o,
   input  logic       wb_ack_i,
   input  logic [7:0] tx_data,
   input  logic       tx_valid,
   output logic       tx_ready,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   input  logic       rx_ready,
   output logic       usb_configured,
   output logic       bus_timeout
);

   wbm_state_e state_q, state_d;
   logic [7:0] cnt_q, cnt_d;
   logic       cyc_q, cyc_d;
   logic       stb_q, stb_d;
   logic       we_q, we_d;
   logic [7:0] adr_q, adr_d;
   logic [7:0] dat_q, dat_d;
   logic       cfg_q, cfg_d;
   logic       prio_q, prio_d;   // 0: RX wins a tie, 1: TX wins a tie
   logic       tx_ready_d;
   logic       abort;
   logic       cand_rx, cand_tx;
   logic       fifo_push, fifo_full, fifo_empty;
   logic [7:0] fifo_head;

   usb_wbm_rx_fifo #(
      .AW (RX_FIFO_AW),
      .DW (8)
   ) u_rx_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (fifo_push),
      .push_data (wb_dat_i),
      .pop       (rx_ready),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .head      (fifo_head)
   );

`ifdef USB_WBM_TIMEOUT_EN
   logic [7:0] to_cnt_q, to_cnt_d;
   logic       bus_timeout_q;

   always_comb begin
      abort    = stb_q && !wb_ack_i && (to_cnt_q == 8'(ACK_TIMEOUT - 1));
      to_cnt_d = '0;
      if (stb_q && !wb_ack_i && !abort) to_cnt_d = to_cnt_q + 8'd1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         to_cnt_q      <= '0;
         bus_timeout_q <= 1'b0;
      end else begin
         to_cnt_q      <= to_cnt_d;
         bus_timeout_q <= abort;
      end
   end

   assign bus_timeout = bus_timeout_q;
`else
   assign abort       = 1'b0;
   assign bus_timeout = 1'b0;
`endif

   // Every bus state spends one cycle with stb low before launching, so the slave
   // never sees a fresh strobe while its previous ack is still up.
   always_comb begin
      state_d    = state_q;
      cnt_d      = '0;
      cyc_d      = cyc_q;
      stb_d      = stb_q;
      we_d       = we_q;
      adr_d      = adr_q;
      dat_d      = dat_q;
      cfg_d      = cfg_q;
      prio_d     = prio_q;
      tx_ready_d = 1'b0;
      fifo_push  = 1'b0;
      cand_rx    = 1'b0;
      cand_tx    = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (cnt_q == 8'(POLL_DIV - 1)) state_d = S_POLL;
            else                           cnt_d   = cnt_q + 8'd1;
         end

         S_POLL: begin
            if (!stb_q) begin
               cyc_d = 1'b1;
               stb_d = 1'b1;
               we_d  = 1'b0;
               adr_d = BASE_ADDR + REG_STATUS;
            end else if (abort) begin
               cyc_d   = 1'b0;
               stb_d   = 1'b0;
               cfg_d   = 1'b0;
               state_d = S_IDLE;
            end else if (wb_ack_i) begin
               cyc_d   = 1'b0;
               stb_d   = 1'b0;
               cfg_d   = wb_dat_i[ST_CFG];
               cand_rx = wb_dat_i[ST_RXV] && !fifo_full;
               cand_tx = wb_dat_i[ST_TXR] && tx_valid;
               if (cand_rx && cand_tx) state_d = prio_q ? S_WR_DATA : S_RD_DATA;
               else if (cand_rx)       state_d = S_RD_DATA;
               else if (cand_tx)       state_d = S_WR_DATA;
               else                    state_d = S_IDLE;
            end
         end

         S_RD_DATA: begin
            if (!stb_q) begin
               cyc_d = 1'b1;
               stb_d = 1'b1;
               we_d  = 1'b0;
               adr_d = BASE_ADDR + REG_DATA;
            end else if (abort) begin
               cyc_d   = 1'b0;
               stb_d   = 1'b0;
               cfg_d   = 1'b0;
               state_d = S_IDLE;
            end else if (wb_ack_i) begin
               cyc_d     = 1'b0;
               stb_d     = 1'b0;
               fifo_push = 1'b1;
               prio_d    = ~prio_q;
               state_d   = S_POLL;
            end
         end

         S_WR_DATA: begin
            if (!stb_q) begin
               cyc_d = 1'b1;
               stb_d = 1'b1;
               we_d  = 1'b1;
               adr_d = BASE_ADDR + REG_DATA;
               dat_d = tx_data;
            end else if (abort) begin
               cyc_d   = 1'b0;
               stb_d   = 1'b0;
               we_d    = 1'b0;
               cfg_d   = 1'b0;
               state_d = S_IDLE;
            end else if (wb_ack_i) begin
               cyc_d      = 1'b0;
               stb_d      = 1'b0;
               we_d       = 1'b0;
               tx_ready_d = 1'b1;
               prio_d     = ~prio_q;
               state_d    = S_POLL;
            end
         end

         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         cyc_q   <= 1'b0;
         stb_q   <= 1'b0;
         we_q    <= 1'b0;
         adr_q   <= '0;
         dat_q   <= '0;
         cfg_q   <= 1'b0;
         prio_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         cyc_q   <= cyc_d;
         stb_q   <= stb_d;
         we_q    <= we_d;
         adr_q   <= adr_d;
         dat_q   <= dat_d;
         cfg_q   <= cfg_d;
         prio_q  <= prio_d;
      end
   end

   assign wb_cyc_o       = cyc_q;
   assign wb_stb_o       = stb_q;
   assign wb_we_o        = we_q;
   assign wb_adr_o       = adr_q;
   assign wb_dat_o       = dat_q;
   assign tx_ready       = tx_ready_d;
   assign usb_configured = cfg_q;
   assign rx_valid       = !fifo_empty;
   assign rx_data        = fifo_empty ? 8'h00 : fifo_head;

endmodule

// File: tb/tb_usb_serial_wb_master.sv
// Directed bench for usb_serial_wb_master with a behavioural USB-serial slave and
// scoreboard queues for data-register accesses and received bytes.
module tb_usb_serial_wb_master;

   typedef struct packed {
      logic       we;
      logic [7:0] adr;
      logic [7:0] dat;
   } acc_t;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [7:0] wb_adr_o, wb_dat_o;
   logic [7:0] wb_dat_i;
   logic       wb_cyc_o, wb_stb_o, wb_we_o;
   logic       wb_ack_i;
   logic [7:0] tx_data = 8'h00;
   logic       tx_valid = 1'b0;
   logic       tx_ready;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       rx_ready = 1'b0;
   logic       usb_configured;
   logic       bus_timeout;

   // slave model state
   logic       ack_r = 1'b0;
   logic [7:0] sdat_r = 8'h00;
   logic       slv_cfg = 1'b0;
   logic       slv_txr = 1'b0;
   logic       slv_noack = 1'b0;
   logic [7:0] host_q[$];
   acc_t       acc_q[$];

   // scoreboard
   acc_t       exp_acc[$];
   logic [7:0] exp_rx[$];

   int         n_assert = 0;
   int         n_fail = 0;
   logic [7:0] last_prev_adr;

   assign wb_ack_i = ack_r;
   assign wb_dat_i = sdat_r;

   usb_serial_wb_master #(
      .BASE_ADDR   (8'h20),
      .POLL_DIV    (8),
      .RX_FIFO_AW  (2),
      .ACK_TIMEOUT (15)
   ) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .wb_adr_o       (wb_adr_o),
      .wb_dat_o       (wb_dat_o),
      .wb_dat_i       (wb_dat_i),
      .wb_cyc_o       (wb_cyc_o),
      .wb_stb_o       (wb_stb_o),
      .wb_we_o        (wb_we_o),
      .wb_ack_i       (wb_ack_i),
      .tx_data        (tx_data),
      .tx_valid       (tx_valid),
      .tx_ready       (tx_ready),
      .rx_data        (rx_data),
      .rx_valid       (rx_valid),
      .rx_ready       (rx_ready),
      .usb_configured (usb_configured),
      .bus_timeout    (bus_timeout)
   );

   always #5 clk = ~clk;

   // Slave: registered ack one cycle after strobe; reading data pops the host queue.
   always @(posedge clk) begin
      if (wb_cyc_o && wb_stb_o && !ack_r && !slv_noack) begin
         ack_r <= 1'b1;
         acc_q.push_back({wb_we_o, wb_adr_o, wb_we_o ? wb_dat_o : 8'h00});
         if (!wb_we_o) begin
            if (wb_adr_o == 8'h21)
               sdat_r <= {slv_cfg, 5'b00000, slv_txr, (host_q.size() != 0)};
            else if (host_q.size() != 0)
               sdat_r <= host_q.pop_front();
            else
               sdat_r <= 8'h00;
         end
      end else begin
         ack_r <= 1'b0;
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
         $error("check %s", tag);
      end
   endtask

   task automatic next_data_acc(input string tag);
      acc_t       a;
      logic [16:0] av;
      logic [7:0] prev;
      int         n;
      bit         got;
      acc_t       e;
      prev = 8'h00;
      n    = 0;
      got  = 1'b0;
      a    = '0;
      while (!got && n < 400) begin
         if (acc_q.size() != 0) begin
            a = acc_q.pop_front();
            if (a.adr == 8'h20) got = 1'b1;
            else                prev = a.adr;
         end else begin
            @(negedge clk);
            n++;
         end
      end
      av = a;
      e  = exp_acc.pop_front();
      check(tag, got ? av : 17'h1ffff, e);
      last_prev_adr = prev;
   endtask

   task automatic pop_rx(input string tag);
      logic [7:0] e;
      int n;
      n = 0;
      while (!rx_valid && n < 400) begin
         @(negedge clk);
         n++;
      end
      e = exp_rx.pop_front();
      check({tag, "-valid"}, rx_valid, 1);
      check(tag, rx_data, e);
      rx_ready = 1'b1;
      @(negedge clk);
      rx_ready = 1'b0;
   endtask

   task automatic wait_tx_ready(input string tag);
      int n;
      n = 0;
      while (!tx_ready && n < 400) begin
         @(negedge clk);
         n++;
      end
      check(tag, tx_ready, 1);
   endtask

   initial begin
      int         n;
      int         nd, np;
      logic [7:0] txb [3];
      txb[0] = 8'hA1;
      txb[1] = 8'hA2;
      txb[2] = 8'hA3;

      // ---- reset state ----
      repeat (3) @(negedge clk);
      check("rst_wb", {wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o}, 19'h0);
      check("rst_tx_ready", tx_ready, 0);
      check("rst_rx", {rx_valid, rx_data}, 9'h0);
      check("rst_cfg", usb_configured, 0);
      check("rst_timeout", bus_timeout, 0);
      rst_n = 1'b1;

      // ---- single RX byte, status 0x81 ----
      repeat (5) @(negedge clk);
      slv_cfg = 1'b1;
      host_q.push_back(8'h5A);
      exp_rx.push_back(8'h5A);
      exp_acc.push_back('{we: 1'b0, adr: 8'h20, dat: 8'h00});
      next_data_acc("t1_rd");
      check("t1_prev_poll", last_prev_adr, 8'h21);
      pop_rx("t1_rx");
      check("t1_cfg", usb_configured, 1);

      // ---- single TX byte, status 0x82 ----
      tx_data  = 8'hC3;
      tx_valid = 1'b1;
      slv_txr  = 1'b1;
      exp_acc.push_back('{we: 1'b1, adr: 8'h20, dat: 8'hC3});
      wait_tx_ready("t2_tx_ready");
      check("t2_bus", {wb_we_o, wb_adr_o, wb_dat_o}, {1'b1, 8'h20, 8'hC3});
      tx_valid = 1'b0;
      slv_txr  = 1'b0;
      @(negedge clk);
      check("t2_pulse_width", tx_ready, 0);
      next_data_acc("t2_wr");

      // ---- both sources pending: RD/WR alternate ----
      for (int k = 0; k < 3; k++) begin
         host_q.push_back(8'(k + 1));
         exp_rx.push_back(8'(k + 1));
         exp_acc.push_back('{we: 1'b0, adr: 8'h20, dat: 8'h00});
         exp_acc.push_back('{we: 1'b1, adr: 8'h20, dat: txb[k]});
      end
      tx_data  = txb[0];
      tx_valid = 1'b1;
      slv_txr  = 1'b1;
      for (int k = 0; k < 3; k++) begin
         wait_tx_ready($sformatf("t3_tx_ready%0d", k));
         check($sformatf("t3_wdat%0d", k), wb_dat_o, txb[k]);
         if (k < 2) tx_data = txb[k + 1];
         else begin
            tx_valid = 1'b0;
            slv_txr  = 1'b0;
         end
         @(negedge clk);
      end
      for (int k = 0; k < 6; k++) next_data_acc($sformatf("t3_acc%0d", k));
      for (int k = 0; k < 3; k++) pop_rx($sformatf("t3_rx%0d", k));

      // ---- FIFO full back-pressure: 5 bytes, depth 4 ----
      for (int k = 0; k < 5; k++) begin
         host_q.push_back(8'h10 + 8'(k));
         exp_rx.push_back(8'h10 + 8'(k));
         exp_acc.push_back('{we: 1'b0, adr: 8'h20, dat: 8'h00});
      end
      for (int k = 0; k < 4; k++) next_data_acc($sformatf("t4_rd%0d", k));
      repeat (150) @(negedge clk);
      nd = 0;
      np = 0;
      foreach (acc_q[i]) begin
         if (acc_q[i].adr == 8'h20) nd++;
         else                       np++;
      end
      check("t4_no_extra_read", nd, 0);
      check("t4_polls_continue", (np > 0), 1);
      check("t4_host_left", host_q.size(), 1);
      pop_rx("t4_rx0");
      next_data_acc("t4_rd4");
      for (int k = 1; k < 5; k++) pop_rx($sformatf("t4_rx%0d", k));

`ifdef USB_WBM_TIMEOUT_EN
      // ---- ack timeout ----
      slv_noack = 1'b1;
      n = 0;
      while (wb_stb_o && n < 100) begin @(negedge clk); n++; end
      n = 0;
      while (!wb_stb_o && n < 400) begin @(negedge clk); n++; end
      n = 0;
      while (wb_stb_o && n < 100) begin @(negedge clk); n++; end
      check("t5_stb_cycles", n, 15);
      check("t5_bus_timeout", bus_timeout, 1);
      check("t5_cfg_cleared", usb_configured, 0);
      @(negedge clk);
      check("t5_pulse_width", bus_timeout, 0);
      repeat (4) @(negedge clk);
      check("t5_idle", wb_cyc_o, 0);
      slv_noack = 1'b0;
      repeat (30) @(negedge clk);
      acc_q.delete();
`else
      check("t5_timeout_tied", bus_timeout, 0);
`endif

      // ---- reset mid-transfer ----
      host_q.push_back(8'h77);
      n = 0;
      while (!rx_valid && n < 400) begin @(negedge clk); n++; end
      check("t6_fifo_filled", rx_valid, 1);
      n = 0;
      while (!wb_stb_o && n < 400) begin @(negedge clk); n++; end
      #1 rst_n = 1'b0;
      #1;
      check("t6_async_wb", {wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o}, 19'h0);
      check("t6_fifo_flushed", rx_valid, 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      acc_q.delete();
      n = 0;
      while (acc_q.size() == 0 && n < 400) begin @(negedge clk); n++; end
      check("t6_first_access", (acc_q.size() != 0) ? {acc_q[0].we, acc_q[0].adr} : 9'h1ff,
            {1'b0, 8'h21});

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
